// File: rtl/read_master.sv
// AXI4 read master for the DMA path: fetches a word-aligned byte range in INCR bursts
// of at most 16 beats that never cross a 4 KB page, pushing each beat into the DMA FIFO.
module read_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [31:0]                   i_src_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_read_done,
  output logic                          o_read_err,
  output logic                          o_busy,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [31:0]                   o_fifo_wdata,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned AW        = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned WCW       = 30;
  localparam int unsigned BW        = 5;
  localparam int unsigned MAX_BEATS = 16;

  typedef enum logic [1:0] {IDLE, AR_PHASE, R_PHASE} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [WCW-1:0] rem_q, rem_d;
  logic [BW-1:0]  words_q, words_d;
  logic [BW-1:0]  exp_q, exp_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [AW-1:0]  araddr_q, araddr_d;
  logic [7:0]     arlen_q, arlen_d;
  logic           arvalid_q, arvalid_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [AW-1:0]  sz_addr_c;
  logic [WCW-1:0] sz_rem_c;
  logic [10:0]    bnd_words_c;
  logic [BW-1:0]  sz_words_c;
  logic           load_burst_c;
  logic           r_hs_c;
  logic           last_exp_c;
  logic           unused_c;

  assign unused_c = &{1'b0, i_total_len[1:0]};

  // Next burst size: min(remaining words, 16, words left before the 4 KB page edge)
  always_comb begin
    sz_addr_c   = (state_q == IDLE) ? AW'(i_src_addr) : addr_q;
    sz_rem_c    = (state_q == IDLE) ? i_total_len[31:2] : rem_q;
    bnd_words_c = 11'((13'h1000 - {1'b0, sz_addr_c[11:0]}) >> 2);
    sz_words_c  = BW'(MAX_BEATS);
    if (sz_rem_c < WCW'(MAX_BEATS)) sz_words_c = BW'(sz_rem_c);
    if (bnd_words_c < 11'(sz_words_c)) sz_words_c = BW'(bnd_words_c);
  end

  assign m_axi_rready = (state_q == R_PHASE) && !i_fifo_full;
  assign r_hs_c       = m_axi_rvalid && m_axi_rready;
  assign last_exp_c   = (beat_q + BW'(1)) == exp_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    words_d      = words_q;
    exp_d        = exp_q;
    beat_d       = beat_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    done_d       = 1'b0;
    err_d        = err_q;
    load_burst_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          err_d = 1'b0;
          if (sz_rem_c != '0) begin
            addr_d       = AW'(i_src_addr);
            rem_d        = i_total_len[31:2];
            load_burst_c = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      AR_PHASE: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          exp_d     = words_q;
          beat_d    = '0;
          addr_d    = addr_q + AW'({words_q, 2'b00});
          rem_d     = rem_q - WCW'(words_q);
          state_d   = R_PHASE;
        end
      end
      R_PHASE: begin
        if (r_hs_c) begin
          beat_d = beat_q + BW'(1);
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_exp_c)) err_d = 1'b1;
          // rlast ends the burst even when it arrives early or late
          if (m_axi_rlast) begin
            if (rem_q == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              load_burst_c = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_burst_c) begin
      words_d   = sz_words_c;
      araddr_d  = sz_addr_c;
      arlen_d   = 8'(sz_words_c - BW'(1));
      arvalid_d = 1'b1;
      state_d   = AR_PHASE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      exp_q     <= '0;
      beat_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      words_q   <= words_d;
      exp_q     <= exp_d;
      beat_q    <= beat_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign o_read_done   = done_q;
  assign o_read_err    = err_q;
  assign o_busy        = (state_q != IDLE);
  assign o_fifo_wr_en  = r_hs_c;
  assign o_fifo_wdata  = r_hs_c ? 32'(m_axi_rdata) : 32'h0;

endmodule

// File: tb/tb_read_master.sv
// Directed bench for read_master with a single-outstanding AXI read slave model and FIFO monitor.
module tb_read_master;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_total_len;
  logic        o_read_done;
  logic        o_read_err;
  logic        o_busy;
  logic        i_fifo_full;
  logic        o_fifo_wr_en;
  logic [31:0] o_fifo_wdata;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  read_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_src_addr   (i_src_addr),
    .i_total_len  (i_total_len),
    .o_read_done  (o_read_done),
    .o_read_err   (o_read_err),
    .o_busy       (o_busy),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_wr_en (o_fifo_wr_en),
    .o_fifo_wdata (o_fifo_wdata),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  logic [31:0] fifo_log[$];
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  int          cyc;
  int          last_wr_cyc;
  int          done_cyc;
  int          done_cnt;
  int          done_base;
  int          ar_stall;
  int          bad_beat;
  int          slv_beat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave: decides handshakes from stable mid-cycle values, updates just after the edge
  initial begin
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] ar_addr_s;
    logic [7:0]  ar_len_s;
    logic [31:0] cur_addr;
    int          cur_left;
    cur_addr = 32'h0;
    cur_left = 0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = 32'h0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs     = m_axi_arvalid && m_axi_arready;
      r_hs      = m_axi_rvalid && m_axi_rready;
      ar_addr_s = m_axi_araddr;
      ar_len_s  = m_axi_arlen;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        cur_left      = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
      end else begin
        if (r_hs) begin
          cur_addr = cur_addr + 32'd4;
          cur_left--;
          slv_beat++;
        end
        if (ar_hs) begin
          ar_addr_log.push_back(ar_addr_s);
          ar_len_log.push_back(ar_len_s);
          cur_addr = ar_addr_s;
          cur_left = int'(ar_len_s) + 1;
        end
        m_axi_arready = (ar_stall == 0);
        if (m_axi_arvalid && ar_stall > 0) ar_stall--;
        if (cur_left > 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = mem_word(cur_addr);
          m_axi_rlast  = (cur_left == 1);
          m_axi_rresp  = (slv_beat + 1 == bad_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
        end
      end
    end
  end

  // FIFO / completion monitor
  always @(negedge clk) begin
    cyc++;
    if (o_fifo_wr_en) begin
      fifo_log.push_back(o_fifo_wdata);
      last_wr_cyc = cyc;
    end
    if (o_read_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] len);
    fifo_log.delete();
    ar_addr_log.delete();
    ar_len_log.delete();
    done_base = done_cnt;
    slv_beat  = 0;
    @(posedge clk);
    #1;
    i_src_addr  = src;
    i_total_len = len;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      if (done_cnt != done_base) begin
        @(negedge clk);
        check("done_width", 32'(o_read_done), 32'd0);
        check("done_count", 32'(done_cnt - done_base), 32'd1);
        return;
      end
      @(posedge clk);
      #1;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_ar(input int idx, input logic [31:0] a, input logic [7:0] l);
    check("ar_addr", (idx < ar_addr_log.size()) ? ar_addr_log[idx] : 32'hDEAD_BEEF, a);
    check("ar_len", (idx < ar_len_log.size()) ? 32'(ar_len_log[idx]) : 32'hDEAD_BEEF, 32'(l));
  endtask

  task automatic check_data(input logic [31:0] src, input int n);
    check("fifo_count", 32'(fifo_log.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check("fifo_data", (i < fifo_log.size()) ? fifo_log[i] : 32'hDEAD_BEEF,
            mem_word(src + 32'(4 * i)));
    check("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; last_wr_cyc = 0; done_cyc = 0;
    done_cnt = 0; done_base = 0; ar_stall = 0; bad_beat = 0; slv_beat = 0;
    reset_n = 1'b0; i_start = 1'b0; i_src_addr = 32'h0; i_total_len = 32'h0; i_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_araddr", m_axi_araddr, 32'h0);
    check("rst_arlen", 32'(m_axi_arlen), 32'd0);
    check("rst_arsize", 32'(m_axi_arsize), 32'd2);
    check("rst_arburst", 32'(m_axi_arburst), 32'd1);
    check("rst_rready", 32'(m_axi_rready), 32'd0);
    check("rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_read_done), 32'd0);
    check("rst_err", 32'(o_read_err), 32'd0);
    reset_n = 1'b1;

    // single full-size burst
    start_xfer(32'h1000_0000, 32'd64);
    check("t1_busy", 32'(o_busy), 32'd1);
    wait_done();
    check("t1_ar_count", 32'(ar_addr_log.size()), 32'd1);
    check_ar(0, 32'h1000_0000, 8'd15);
    check_data(32'h1000_0000, 16);
    check("t1_err", 32'(o_read_err), 32'd0);

    // 4 KB boundary split
    start_xfer(32'h0000_0FF0, 32'd64);
    wait_done();
    check("t2_ar_count", 32'(ar_addr_log.size()), 32'd2);
    check_ar(0, 32'h0000_0FF0, 8'd3);
    check_ar(1, 32'h0000_1000, 8'd11);
    check_data(32'h0000_0FF0, 16);

    // 25 words: 16 + 9
    start_xfer(32'h0000_2000, 32'd100);
    wait_done();
    check("t3_ar_count", 32'(ar_addr_log.size()), 32'd2);
    check_ar(0, 32'h0000_2000, 8'd15);
    check_ar(1, 32'h0000_2040, 8'd8);
    check_data(32'h0000_2000, 25);

    // FIFO full over beats 5..8
    start_xfer(32'h0000_6000, 32'd64);
    for (int i = 0; i < 200; i++) begin
      if (fifo_log.size() >= 4) break;
      @(posedge clk);
      #1;
    end
    check("t4_pre_full_count", 32'(fifo_log.size()), 32'd4);
    i_fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_full_rready", 32'(m_axi_rready), 32'd0);
      check("t4_full_wr_en", 32'(o_fifo_wr_en), 32'd0);
    end
    @(posedge clk);
    #1;
    i_fifo_full = 1'b0;
    wait_done();
    check("t4_ar_count", 32'(ar_addr_log.size()), 32'd1);
    check_data(32'h0000_6000, 16);

    // SLVERR on beat 3: sticky error, transfer completes, next start clears it
    bad_beat = 3;
    start_xfer(32'h0000_4000, 32'd32);
    wait_done();
    check("t5_err_sticky", 32'(o_read_err), 32'd1);
    check_data(32'h0000_4000, 8);
    bad_beat = 0;
    start_xfer(32'h0000_7000, 32'd4);
    @(negedge clk);
    check("t5_err_cleared", 32'(o_read_err), 32'd0);
    wait_done();
    check("t5_err_after", 32'(o_read_err), 32'd0);
    check_ar(0, 32'h0000_7000, 8'd0);
    check_data(32'h0000_7000, 1);

    // zero word count: done pulse only
    start_xfer(32'h0000_8000, 32'd3);
    wait_done();
    check("t6_ar_count", 32'(ar_addr_log.size()), 32'd0);
    check("t6_fifo_count", 32'(fifo_log.size()), 32'd0);
    check("t6_busy", 32'(o_busy), 32'd0);

    // arready stall, ignored start while busy, then reset mid-burst
    ar_stall = 5;
    start_xfer(32'h0000_3000, 32'd64);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axi_arvalid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t7_stall_arvalid", 32'(m_axi_arvalid), 32'd1);
      check("t7_stall_araddr", m_axi_araddr, 32'h0000_3000);
      check("t7_stall_arlen", 32'(m_axi_arlen), 32'd15);
      if (i == 1) begin
        i_src_addr = 32'h0000_5000;
        i_start    = 1'b1;
      end
      if (i == 2) i_start = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      if (fifo_log.size() >= 3) break;
      @(posedge clk);
      #1;
    end
    check("t7_pre_rst_count", 32'(fifo_log.size()), 32'd3);
    #3;
    reset_n = 1'b0;
    #1;
    check("t7_rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("t7_rst_rready", 32'(m_axi_rready), 32'd0);
    check("t7_rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("t7_rst_busy", 32'(o_busy), 32'd0);
    check("t7_rst_araddr", m_axi_araddr, 32'h0);
    check("t7_rst_arlen", 32'(m_axi_arlen), 32'd0);
    check("t7_rst_done", 32'(o_read_done), 32'd0);
    check("t7_rst_err", 32'(o_read_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("t7_ar_count", 32'(ar_addr_log.size()), 32'd1);
    check_ar(0, 32'h0000_3000, 8'd15);
    start_xfer(32'h1000_0000, 32'd16);
    wait_done();
    check("t7_post_ar_count", 32'(ar_addr_log.size()), 32'd1);
    check_ar(0, 32'h1000_0000, 8'd3);
    check_data(32'h1000_0000, 4);
    check("t7_post_err", 32'(o_read_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
